// File: rtl/ram_sweep.sv
// ram_sweep: parametrised single-port RAM with a hardware clear sweep.
// After reset, or when clear is requested, every word is written with
// INIT_VAL, one word per clock, before normal access resumes.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset; restarts the clear sweep
//   load     write enable; in -> word[address] on a rising edge when idle
//   address  read/write address
//   in       write data
//   clear    request a full-array clear sweep
//   out      read data; combinational read when idle, INIT_VAL while sweeping
//   busy     high while a clear sweep is in progress
module ram_sweep #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      ADDR_W   = 3,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               we_c;
    logic [ADDR_W-1:0]  waddr_c;
    logic [WIDTH-1:0]   wdata_c;

    // State and sweep pointer; reset always restarts the sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state and the single write port: the sweep owns it while busy.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_c    = 1'b0;
        waddr_c = address;
        wdata_c = in;
        case (state_q)
            SWEEP: begin
                we_c    = 1'b1;
                waddr_c = ptr_q;
                wdata_c = INIT_VAL;
                ptr_d   = ADDR_W'(ptr_q + 1'b1);
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // clear has priority; a simultaneous write is dropped
                if (clear) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end else if (load) begin
                    we_c = 1'b1;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage array; no reset, the sweep initialises it.
    always_ff @(posedge clk) begin
        if (rst_n && we_c) begin
            mem[waddr_c] <= wdata_c;
        end
    end

    // Array may hold stale data mid-sweep, so the read is masked until idle.
    assign out  = (state_q == IDLE) ? mem[address] : INIT_VAL;
    assign busy = (state_q == SWEEP);

endmodule

// File: tb/tb_ram_sweep.sv
module tb_ram_sweep;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance: 16 x 8, INIT_VAL = 0
    logic        rst_n, load, clear, busy;
    logic [2:0]  address;
    logic [15:0] din, dout;

    // second instance: 8 x 32, INIT_VAL = A5
    logic        rst2_n, load2, clear2, busy2;
    logic [4:0]  address2;
    logic [7:0]  din2, dout2;

    int total = 0;
    int bad   = 0;

    ram_sweep dut (
        .clk(clk), .rst_n(rst_n), .load(load), .address(address),
        .in(din), .clear(clear), .out(dout), .busy(busy)
    );

    ram_sweep #(.WIDTH(8), .ADDR_W(5), .INIT_VAL(8'hA5)) dut2 (
        .clk(clk), .rst_n(rst2_n), .load(load2), .address(address2),
        .in(din2), .clear(clear2), .out(dout2), .busy(busy2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // advance one rising edge, land 2ns after it
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // count edges with busy high; also note whether out held INIT_VAL
    task automatic count_busy(input bit sel, output int n, output bit out_ok);
        n      = 0;
        out_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ((sel ? busy2 : busy) !== 1'b1) break;
            if (sel ? (dout2 !== 8'hA5) : (dout !== 16'h0000)) out_ok = 1'b0;
            n++;
            step();
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        address = a;
        step();
        chk(tag, 32'(dout), 32'(exp));
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a;
        din     = d;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    initial begin
        int          n;
        bit          ok;
        logic [15:0] walk_exp [8];
        walk_exp = '{16'h0000, 16'h0000, 16'h0001, 16'h0001,
                     16'h0002, 16'h0002, 16'h0003, 16'h0003};

        rst_n = 1'b0; load = 1'b0; clear = 1'b0; address = '0; din = '0;
        rst2_n = 1'b0; load2 = 1'b0; clear2 = 1'b0; address2 = '0; din2 = '0;

        // reset and initial sweep
        #2;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_out", 32'(dout), 32'h0000);
        #10;
        rst_n = 1'b1;
        count_busy(1'b0, n, ok);
        chk("init_busy_edges", 32'(n), 32'd8);
        chk("init_out_forced", 32'(ok), 32'd1);
        for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "init_word");

        // single write, hold, neighbour
        wr(3'd3, 16'h1234);
        chk("wr_imm", 32'(dout), 32'h1234);
        din = 16'hFFFF;
        step();
        chk("wr_hold", 32'(dout), 32'h1234);
        address = 3'd4;
        #1;
        chk("wr_neigh", 32'(dout), 32'h0000);

        // walk: address every 2 cycles, data every 4 cycles, 16 cycles of load
        for (int c = 0; c < 16; c++) begin
            address = 3'(c / 2);
            din     = 16'(c / 4);
            load    = 1'b1;
            step();
        end
        load = 1'b0;
        for (int k = 0; k < 8; k++) rd(3'(k), walk_exp[k], "walk_word");

        // fill nonzero, then clear sweep with blocked write attempts
        for (int k = 0; k < 8; k++) wr(3'(k), 16'(16'h1111 * (k + 1)));
        rd(3'd6, 16'h7777, "fill_word6");
        clear = 1'b1;
        step();
        clear   = 1'b0;
        chk("clr_busy_now", 32'(busy), 32'd1);
        address = 3'd2; din = 16'hABCD; load = 1'b1;
        count_busy(1'b0, n, ok);
        load = 1'b0;
        chk("clr_busy_edges", 32'(n), 32'd8);
        chk("clr_out_forced", 32'(ok), 32'd1);
        for (int k = 0; k < 8; k++) rd(3'(k), 16'h0000, "clr_word");

        // load and clear on the same edge: clear wins
        wr(3'd5, 16'h9999);
        rd(3'd5, 16'h9999, "pre_conflict");
        address = 3'd5; din = 16'h5555; load = 1'b1; clear = 1'b1;
        step();
        load = 1'b0; clear = 1'b0;
        count_busy(1'b0, n, ok);
        chk("conf_busy_edges", 32'(n), 32'd8);
        rd(3'd5, 16'h0000, "conf_word5");

        // reset mid-sweep at ptr=4 restarts a full sweep
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd1);
        chk("mid_rst_out", 32'(dout), 32'h0000);
        step();
        rst_n = 1'b1;
        count_busy(1'b0, n, ok);
        chk("mid_restart_edges", 32'(n), 32'd8);

        // 8-bit x 32 instance with INIT_VAL=A5
        rst2_n = 1'b1;
        count_busy(1'b1, n, ok);
        chk("w8_busy_edges", 32'(n), 32'd32);
        chk("w8_out_forced", 32'(ok), 32'd1);
        for (int k = 0; k < 32; k++) begin
            address2 = 5'(k);
            step();
            chk("w8_word", 32'(dout2), 32'hA5);
        end
        address2 = 5'd31; din2 = 8'h3C; load2 = 1'b1;
        step();
        load2 = 1'b0;
        chk("w8_wr31", 32'(dout2), 32'h3C);
        address2 = 5'd30;
        #1;
        chk("w8_word30", 32'(dout2), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
